led_frame_counter: RTL and testbench

//  Parametrised bit/LED position counter for the GRB serial LED driver.
//  It replaces the flat bit counter that the GRB state machine drives.

---
 rtl/led_frame_counter_if.sv | 33 +++
 rtl/led_frame_counter.sv | 104 ++++++++++
 tb/tb_led_frame_counter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/led_frame_counter_if.sv
// Control/status bundle between the GRB LED state machine (master) and the
// frame position counter (slave).
interface led_frame_counter_if #(
  parameter int unsigned NUM_LEDS     = 300,
  parameter int unsigned BITS_PER_LED = 24
);
  localparam int unsigned TOTAL   = NUM_LEDS * BITS_PER_LED;
  localparam int unsigned COUNT_W = $clog2(TOTAL);
  localparam int unsigned LED_W   = $clog2(NUM_LEDS);
  localparam int unsigned BIT_W   = $clog2(BITS_PER_LED);

  logic               clear;
  logic               inc;
  logic               load;
  logic [LED_W-1:0]   load_led;
  logic [COUNT_W-1:0] count;
  logic [BIT_W-1:0]   bit_idx;
  logic [LED_W-1:0]   led_idx;
  logic               last_bit;
  logic               at_last;
  logic               frame_done;
  logic               overflow;

  modport master (
    output clear, inc, load, load_led,
    input  count, bit_idx, led_idx, last_bit, at_last, frame_done, overflow
  );

  modport slave (
    input  clear, inc, load, load_led,
    output count, bit_idx, led_idx, last_bit, at_last, frame_done, overflow
  );
endinterface

// File: rtl/led_frame_counter.sv
// Bit/LED position counter for the GRB serial LED driver: flat bit count,
// bit-within-LED and LED index stepped together, frame-end pulse, sticky misuse flag.
module led_frame_counter #(
  parameter int unsigned NUM_LEDS     = 300,
  parameter int unsigned BITS_PER_LED = 24,
  parameter bit          WRAP         = 1'b1
) (
  input logic               clk,
  input logic               reset,
  led_frame_counter_if.slave bus
);
  localparam int unsigned TOTAL   = NUM_LEDS * BITS_PER_LED;
  localparam int unsigned COUNT_W = $clog2(TOTAL);
  localparam int unsigned LED_W   = $clog2(NUM_LEDS);
  localparam int unsigned BIT_W   = $clog2(BITS_PER_LED);

  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(TOTAL - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_LED - 1);
  localparam logic [LED_W-1:0]   LED_LAST   = LED_W'(NUM_LEDS - 1);
  localparam logic [COUNT_W-1:0] BPL_C      = COUNT_W'(BITS_PER_LED);
  localparam logic [LED_W:0]     NUM_LEDS_C = (LED_W + 1)'(NUM_LEDS);

  typedef enum logic {RUN, HOLD} state_t;

  state_t             state_q;
  logic [COUNT_W-1:0] count_q;
  logic [BIT_W-1:0]   bit_q;
  logic [LED_W-1:0]   led_q;
  logic               frame_done_q;
  logic               overflow_q;

  logic               last_bit;
  logic               at_last;
  logic               load_ok;
  logic [COUNT_W-1:0] load_count;

  assign last_bit   = (bit_q == BIT_LAST);
  assign at_last    = (count_q == COUNT_LAST);
  // Extra MSB so a power-of-two NUM_LEDS still compares correctly.
  assign load_ok    = ({1'b0, bus.load_led} < NUM_LEDS_C);
  assign load_count = COUNT_W'(bus.load_led) * BPL_C;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      count_q      <= '0;
      bit_q        <= '0;
      led_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (bus.clear) begin
        state_q    <= RUN;
        count_q    <= '0;
        bit_q      <= '0;
        led_q      <= '0;
        overflow_q <= 1'b0;
      end else if (bus.load) begin
        if (load_ok) begin
          state_q <= RUN;
          count_q <= load_count;
          bit_q   <= '0;
          led_q   <= bus.load_led;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (bus.inc) begin
        if (state_q == HOLD) begin
          overflow_q <= 1'b1;
        end else if (at_last) begin
          frame_done_q <= 1'b1;
          if (WRAP) begin
            count_q <= '0;
            bit_q   <= '0;
            led_q   <= '0;
          end else begin
            // Park on the final bit; only clear or a valid load leaves HOLD.
            state_q <= HOLD;
            count_q <= COUNT_LAST;
            bit_q   <= BIT_LAST;
            led_q   <= LED_LAST;
          end
        end else begin
          count_q <= count_q + 1'b1;
          if (last_bit) begin
            bit_q <= '0;
            led_q <= led_q + 1'b1;
          end else begin
            bit_q <= bit_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.bit_idx    = bit_q;
  assign bus.led_idx    = led_q;
  assign bus.last_bit   = last_bit;
  assign bus.at_last    = at_last;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_led_frame_counter.sv
// Bench for led_frame_counter: a WRAP=1 and a WRAP=0 instance driven with the same
// stimulus, checked against a position-based model, a vector table and random traffic.
module tb_led_frame_counter;
  localparam int NL  = 3;
  localparam int BPL = 4;
  localparam int TOT = NL * BPL;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_s, inc_s, ld_s;
  logic [1:0] ll_s;

  always #5 clk = ~clk;

  led_frame_counter_if #(.NUM_LEDS(NL), .BITS_PER_LED(BPL)) if_w ();
  led_frame_counter_if #(.NUM_LEDS(NL), .BITS_PER_LED(BPL)) if_h ();

  assign if_w.clear = clr_s;
  assign if_w.inc = inc_s;
  assign if_w.load = ld_s;
  assign if_w.load_led = ll_s;
  assign if_h.clear = clr_s;
  assign if_h.inc = inc_s;
  assign if_h.load = ld_s;
  assign if_h.load_led = ll_s;

  led_frame_counter #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .bus(if_w));
  led_frame_counter #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .WRAP(1'b0)) dut_h (
    .clk(clk), .reset(reset), .bus(if_h));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: index 0 = WRAP=1 instance, index 1 = WRAP=0 instance.
  int m_pos[2];
  bit m_hold[2];
  bit m_ov[2];
  bit m_fd[2];

  typedef struct {
    int c, i, l, ll, rep;
    int ew, eh, fdw, fdh, ovw, ovh;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_hold[k] = 0; m_ov[k] = 0; m_fd[k] = 0;
    end
  endtask

  task automatic model_step(bit c, bit i, bit l, int ll);
    for (int k = 0; k < 2; k++) begin
      m_fd[k] = 0;
      if (c) begin
        m_pos[k] = 0; m_hold[k] = 0; m_ov[k] = 0;
      end else if (l) begin
        if (ll < NL) begin
          m_pos[k] = ll * BPL; m_hold[k] = 0;
        end else begin
          m_ov[k] = 1;
        end
      end else if (i) begin
        if (m_hold[k]) m_ov[k] = 1;
        else if (m_pos[k] == TOT - 1) begin
          m_fd[k] = 1;
          if (k == 0) m_pos[k] = 0;
          else m_hold[k] = 1;
        end else m_pos[k] = m_pos[k] + 1;
      end
    end
  endtask

  task automatic check_dut(int k, string tag, int pos, bit fd, bit ov);
    logic [31:0] cnt, led, bt, lb, al, fdv, ovv;
    if (k == 0) begin
      cnt = 32'(if_w.count); led = 32'(if_w.led_idx); bt = 32'(if_w.bit_idx);
      lb = 32'(if_w.last_bit); al = 32'(if_w.at_last);
      fdv = 32'(if_w.frame_done); ovv = 32'(if_w.overflow);
    end else begin
      cnt = 32'(if_h.count); led = 32'(if_h.led_idx); bt = 32'(if_h.bit_idx);
      lb = 32'(if_h.last_bit); al = 32'(if_h.at_last);
      fdv = 32'(if_h.frame_done); ovv = 32'(if_h.overflow);
    end
    chk({tag, ".count"}, cnt, 32'(pos));
    chk({tag, ".led_idx"}, led, 32'(pos / BPL));
    chk({tag, ".bit_idx"}, bt, 32'(pos % BPL));
    chk({tag, ".last_bit"}, lb, 32'((pos % BPL) == BPL - 1));
    chk({tag, ".at_last"}, al, 32'(pos == TOT - 1));
    chk({tag, ".frame_done"}, fdv, 32'(fd));
    chk({tag, ".overflow"}, ovv, 32'(ov));
  endtask

  task automatic drive(bit c, bit i, bit l, int ll, string tag);
    clr_s = c; inc_s = i; ld_s = l; ll_s = 2'(ll);
    @(posedge clk);
    #1;
    model_step(c, i, l, ll);
    check_dut(0, {tag, "/W"}, m_pos[0], m_fd[0], m_ov[0]);
    check_dut(1, {tag, "/H"}, m_pos[1], m_fd[1], m_ov[1]);
  endtask

  initial begin
    //          c i l ll rep  ew eh fdw fdh ovw ovh
    tbl[0]  = '{0,1,0,0, 5,   5, 5, 0, 0, 0, 0};
    tbl[1]  = '{0,1,0,0, 2,   7, 7, 0, 0, 0, 0};
    tbl[2]  = '{1,1,0,0, 1,   0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0,1,0,0, 7,   7, 7, 0, 0, 0, 0};
    tbl[4]  = '{0,1,1,0, 1,   0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0,0,1,2, 1,   8, 8, 0, 0, 0, 0};
    tbl[6]  = '{0,0,1,3, 1,   8, 8, 0, 0, 1, 1};
    tbl[7]  = '{1,0,0,0, 1,   0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0,1,0,0, 11, 11,11, 0, 0, 0, 0};
    tbl[9]  = '{0,1,0,0, 1,   0,11, 1, 1, 0, 0};
    tbl[10] = '{0,1,0,0, 1,   1,11, 0, 0, 0, 1};
    tbl[11] = '{1,0,0,0, 1,   0, 0, 0, 0, 0, 0};
    tbl[12] = '{0,1,0,0, 12,  0,11, 1, 1, 0, 0};
    tbl[13] = '{0,1,0,0, 11, 11,11, 0, 0, 0, 1};
    tbl[14] = '{0,1,0,0, 1,   0,11, 1, 0, 0, 1};
    tbl[15] = '{0,0,0,0, 1,   0,11, 0, 0, 0, 1};
    tbl[16] = '{0,0,1,1, 1,   4, 4, 0, 0, 0, 1};
    tbl[17] = '{0,1,0,0, 8,   0,11, 1, 1, 0, 1};
    tbl[18] = '{1,0,0,0, 1,   0, 0, 0, 0, 0, 0};

    reset = 1'b1; clr_s = 0; inc_s = 0; ld_s = 0; ll_s = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_dut(0, "reset/W", 0, 0, 0);
    check_dut(1, "reset/H", 0, 0, 0);
    reset = 1'b0;
    $display("reset done");

    for (int r = 0; r < 19; r++) begin
      for (int n = 0; n < tbl[r].rep; n++)
        drive(tbl[r].c[0], tbl[r].i[0], tbl[r].l[0], tbl[r].ll, $sformatf("row%0d", r));
      check_dut(0, $sformatf("tbl%0d/W", r), tbl[r].ew, tbl[r].fdw[0], tbl[r].ovw[0]);
      check_dut(1, $sformatf("tbl%0d/H", r), tbl[r].eh, tbl[r].fdh[0], tbl[r].ovh[0]);
      $display("row %0d: clr=%0d inc=%0d load=%0d led=%0d x%0d -> W count=%0d H count=%0d",
               r, tbl[r].c, tbl[r].i, tbl[r].l, tbl[r].ll, tbl[r].rep,
               if_w.count, if_h.count);
    end

    // Reset mid-frame with inc held high: reset wins, no frame_done afterwards.
    drive(1, 0, 0, 0, "pre_rst");
    for (int n = 0; n < 9; n++) drive(0, 1, 0, 0, "pre_rst");
    clr_s = 0; inc_s = 1; ld_s = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    inc_s = 0;
    model_reset();
    check_dut(0, "midrst/W", 0, 0, 0);
    check_dut(1, "midrst/H", 0, 0, 0);
    for (int n = 0; n < 3; n++) drive(0, 0, 0, 0, "post_rst");
    $display("mid-frame reset: W count=%0d H count=%0d", if_w.count, if_h.count);

    for (int n = 0; n < 600; n++) begin
      bit c, i, l;
      int ll;
      c  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 24) == 0);
      i  = ($urandom_range(0, 99) < 85);
      ll = int'($urandom_range(0, 3));
      drive(c, i, l, ll, $sformatf("rnd%0d", n));
      $display("rnd %0d: clr=%0d inc=%0d load=%0d led=%0d -> W %0d fd=%0d ov=%0d | H %0d fd=%0d ov=%0d",
               n, c, i, l, ll, if_w.count, if_w.frame_done, if_w.overflow,
               if_h.count, if_h.frame_done, if_h.overflow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
